// File: rtl/memory_write_interface.sv
// Byte-serial memory write engine: latches a 32-bit word and its word address, then
// streams the word to a byte-wide memory as four bytes, using a ready handshake and a stall timeout.
module memory_write_interface #(
    parameter int unsigned TIMEOUT    = 15,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addrbus16,
    input  logic [31:0] databus32,
    input  logic        mem_rdy,
    output logic [17:0] addr18,
    output logic [7:0]  data8,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The wait count that aborts on the following stalled edge. A TIMEOUT of 0 never matches.
    localparam logic [7:0] WAIT_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] addr_reg;
    logic [31:0] data_reg;
    logic [1:0]  byte_cnt;
    logic [7:0]  wait_cnt;
    logic        err_flag;
    logic        last_byte;
    logic        timeout_hit;
    logic [1:0]  lane;

    assign last_byte   = (byte_cnt == 2'd3);
    assign timeout_hit = (TIMEOUT != 0) && !mem_rdy && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if ((mem_rdy && last_byte) || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The byte counter never carries into addr_reg, so a transfer stays inside its word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
            data_reg <= '0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_reg <= addrbus16;
                        data_reg <= databus32;
                        byte_cnt <= '0;
                        wait_cnt <= '0;
                        err_flag <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_rdy) begin
                        wait_cnt <= '0;
                        err_flag <= 1'b0;
                        if (!last_byte) byte_cnt <= byte_cnt + 2'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (timeout_hit) err_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state)
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_flag;
            end
            default: ;
        endcase
    end

    assign lane   = BIG_ENDIAN ? ~byte_cnt : byte_cnt;
    assign data8  = data_reg[{lane, 3'b000} +: 8];
    assign addr18 = {addr_reg, byte_cnt};

endmodule

// File: tb/tb_memory_write_interface.sv
// Bench for memory_write_interface: table of transfers with stall patterns, a byte scoreboard
// per instance (little- and big-endian), plus hand sequences for async reset and back-to-back starts.
module tb_memory_write_interface;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] addrbus16 = '0;
    logic [31:0] databus32 = '0;
    logic        mem_rdy = 1'b1;
    logic [17:0] addr18_0, addr18_1;
    logic [7:0]  data8_0, data8_1;
    logic        mem_we0, mem_we1, busy0, busy1, done0, done1, err0, err1;

    memory_write_interface #(.TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start0), .addrbus16(addrbus16), .databus32(databus32),
        .mem_rdy(mem_rdy), .addr18(addr18_0), .data8(data8_0), .mem_we(mem_we0),
        .busy(busy0), .done(done0), .err(err0));

    memory_write_interface #(.TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .start(start1), .addrbus16(addrbus16), .databus32(databus32),
        .mem_rdy(mem_rdy), .addr18(addr18_1), .data8(data8_1), .mem_we(mem_we1),
        .busy(busy1), .done(done1), .err(err1));

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [17:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    typedef struct {
        logic        be;
        logic [15:0] addr;
        logic [31:0] data;
        int          s;     // offset whose presentation is stalled
        int          len;   // stalled cycles on that offset
        logic        poke;  // re-pulse start mid-transfer with another address
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] lane_of(input logic be, input logic [31:0] d, input int k);
        int l;
        l = be ? 3 - k : k;
        return d[8*l +: 8];
    endfunction

    // Scoreboards: a byte is written when mem_we and mem_rdy are both high at the next edge.
    always @(negedge clk) begin : mon0
        wr_t e;
        if (!rst && mem_we0 && mem_rdy) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL extra_write0: got %0h/%0h expected no write", addr18_0, data8_0);
            end else begin
                e = q0.pop_front();
                check("wr_addr0", 32'(addr18_0), 32'(e.a));
                check("wr_data0", 32'(data8_0), 32'(e.d));
            end
        end
    end

    always @(negedge clk) begin : mon1
        wr_t e;
        if (!rst && mem_we1 && mem_rdy) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL extra_write1: got %0h/%0h expected no write", addr18_1, data8_1);
            end else begin
                e = q1.pop_front();
                check("wr_addr1", 32'(addr18_1), 32'(e.a));
                check("wr_data1", 32'(data8_1), 32'(e.d));
            end
        end
    end

    task automatic push_bytes(input logic be, input logic [15:0] a, input logic [31:0] d, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.a = {a, 2'(k)};
            e.d = lane_of(be, d, k);
            if (be) q1.push_back(e);
            else    q0.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit   abort;
        int   exp_done, nbytes, last_off, c;
        bit   found;
        abort    = (v.len >= TO);
        exp_done = abort ? v.s + TO + 1 : 5 + v.len;
        nbytes   = abort ? v.s : 4;
        last_off = abort ? v.s : 3;
        push_bytes(v.be, v.addr, v.data, nbytes);
        @(posedge clk); #1;
        addrbus16 = v.addr;
        databus32 = v.data;
        if (v.be) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;   // edge 0 has sampled start
        start0 = 1'b0;
        start1 = 1'b0;
        found = 1'b0;
        for (c = 1; c <= 40; c++) begin
            mem_rdy = (c > v.s && c <= v.s + v.len) ? 1'b0 : 1'b1;
            if (v.poke && c == 2) begin
                addrbus16 = 16'h5555;
                if (v.be) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            @(negedge clk);
            if (v.be ? done1 : done0) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!found) begin
            total++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", exp_done);
        end else begin
            check("done_cycle", 32'(c), 32'(exp_done));
            check("done_err", 32'(v.be ? err1 : err0), 32'(abort));
            check("done_addr", 32'(v.be ? addr18_1 : addr18_0), 32'({v.addr, 2'(last_off)}));
            check("done_we", 32'(v.be ? mem_we1 : mem_we0), 32'd0);
            check("done_busy", 32'(v.be ? busy1 : busy0), 32'd1);
        end
        mem_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_done", 32'(v.be ? done1 : done0), 32'd0);
        check("idle_busy", 32'(v.be ? busy1 : busy0), 32'd0);
        check("all_written", 32'(v.be ? q1.size() : q0.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 32'hDEADBEEF, 0, 0,   1'b0};
        vecs[1] = '{1'b0, 16'h1234, 32'hDEADBEEF, 1, 3,   1'b0};
        vecs[2] = '{1'b0, 16'h1234, 32'hDEADBEEF, 1, 100, 1'b0};
        vecs[3] = '{1'b0, 16'h1234, 32'hDEADBEEF, 0, 0,   1'b0};
        vecs[4] = '{1'b0, 16'h1234, 32'hDEADBEEF, 0, 0,   1'b1};
        vecs[5] = '{1'b1, 16'hFFFF, 32'h01020304, 0, 0,   1'b0};
        vecs[6] = '{1'b0, 16'hABCD, 32'hCAFEF00D, 3, 14,  1'b0};
        vecs[7] = '{1'b0, 16'h0000, 32'h11223344, 0, 15,  1'b0};
        vecs[8] = '{1'b1, 16'h8001, 32'hA1B2C3D4, 2, 2,   1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(mem_we0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_addr", 32'(addr18_0), 32'd0);
        check("rst_data", 32'(data8_0), 32'd0);
        check("rst_busy_be", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Async reset while offset 10 is presented
        push_bytes(1'b0, 16'h1234, 32'hDEADBEEF, 2);
        @(posedge clk); #1;
        addrbus16 = 16'h1234;
        databus32 = 32'hDEADBEEF;
        start0 = 1'b1;
        mem_rdy = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(negedge clk);
        check("pre_rst_addr", 32'(addr18_0), 32'h048D2);
        #2 rst = 1'b1;
        #1;
        check("async_we", 32'(mem_we0), 32'd0);
        check("async_busy", 32'(busy0), 32'd0);
        check("async_addr", 32'(addr18_0), 32'd0);
        check("async_data", 32'(data8_0), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done0), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rdy = 1'b1;
        check("rst_flushed", 32'(q0.size()), 32'd0);
        q0.delete();
        run_vec(vecs[0]);

        // start held high: back-to-back transfers with one idle cycle between
        push_bytes(1'b0, 16'h0100, 32'h89ABCDEF, 4);
        push_bytes(1'b0, 16'h0100, 32'h89ABCDEF, 4);
        @(posedge clk); #1;
        addrbus16 = 16'h0100;
        databus32 = 32'h89ABCDEF;
        start0 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) start0 = 1'b0;
            @(negedge clk);
            check("cont_done", 32'(done0), 32'(c == 5 || c == 11));
            check("cont_we", 32'(mem_we0), 32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
            @(posedge clk); #1;
        end
        check("cont_written", 32'(q0.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/memory_write_interface.md
Name: memory_write_interface

Overview:
Write-side counterpart of the byte-serial memory read datapath. Accepts a 16-bit word address and a 32-bit data word from the system bus. Writes the word as four consecutive 8-bit bytes to a byte-wide memory with an 18-bit address. Contains its own control FSM, byte counter, memory-ready handshake and stall timeout, and reports completion or error to the bus master.

Parameters:
TIMEOUT, 15, max consecutive cycles one byte may wait for mem_rdy before abort; 0 disables timeout (wait forever); legal range 0..255
BIG_ENDIAN, 0, 0: byte offset 00 carries data[7:0] (matches read-side assembly); 1: offset 00 carries data[31:24]

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  write request; sampled only in IDLE
addrbus16  input  16  word address, captured on accepted start
databus32  input  32  data word, captured on accepted start
mem_rdy  input  1  memory accepts current byte on a rising edge where mem_we=1 and mem_rdy=1
addr18  output  18  memory byte address = {addr_reg, byte_cnt}
data8  output  8  byte currently presented to memory
mem_we  output  1  memory write strobe
busy  output  1  high in WRITE and DONE
done  output  1  one-cycle completion pulse
err  output  1  high with done when the transfer aborted on timeout

Behaviour:
- Reset (async, immediate, mid-operation included):
  - state=IDLE; addr_reg=0, data_reg=0, byte_cnt=0, wait_cnt=0.
  - Outputs: mem_we=0, busy=0, done=0, err=0, addr18=0, data8=0.
  - An in-flight transfer is dropped; no partial completion is reported.
- Registers: addr_reg (16b), data_reg (32b), byte_cnt (2b), wait_cnt (8b), 2-bit state.
- All outputs decode from registers only; there is no combinational path from any input to any output.
- data8 = byte lane selected by byte_cnt per BIG_ENDIAN. Lane k = data_reg[8k+7:8k]; with BIG_ENDIAN=1 the lane is 3-k.
- addr18 and data8 are always driven from the registers. After completion they hold the last byte written (byte_cnt=3, or the aborting offset).
- State IDLE:
  - mem_we=0, busy=0.
  - On start=1: capture addrbus16 and databus32, byte_cnt=0, wait_cnt=0, go WRITE.
- State WRITE:
  - mem_we=1, busy=1.
  - Each edge with mem_rdy=1: the byte is accepted, wait_cnt=0.
    - byte_cnt<3: byte_cnt+1.
    - byte_cnt==3: go DONE with err flag cleared.
  - Each edge with mem_rdy=0: wait_cnt+1.
    - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 at that edge: go DONE with err flag set. The byte is not written; byte_cnt holds.
- State DONE:
  - mem_we=0, busy=1, done=1, err=err flag.
  - Lasts exactly one cycle, then unconditionally go IDLE; err clears with done.
- Handshake rules:
  - start is ignored in WRITE and DONE; there is no queuing.
  - The master holds start low, or re-asserts it after busy falls.
  - start held continuously high starts a new transfer each time IDLE is reached (one idle cycle between transfers).
- Latency with mem_rdy tied 1:
  - Start sampled at edge 0.
  - mem_we high cycles 1–4; bytes accepted at edges 1–4, offsets 00,01,10,11.
  - done high cycle 5; IDLE again cycle 6.
  - Each stalled cycle adds exactly one cycle.
- Address arithmetic: no carry out of byte_cnt into addr_reg. The word at 16'hFFFF writes 18'h3FFFC..18'h3FFFF and never wraps into word 0.
- A stall of exactly TIMEOUT-1 cycles followed by mem_rdy=1 is accepted normally; a stall of TIMEOUT cycles aborts.

Test Plan:
1. Reset, then start with addrbus16=16'h1234, databus32=32'hDEADBEEF, mem_rdy=1, BIG_ENDIAN=0 -> mem_we high 4 cycles; (addr18,data8) = (18'h048D0,EF),(048D1,BE),(048D2,AD),(048D3,DE); done=1, err=0 one cycle after the last byte; total 5 cycles from start.
2. Same transfer with mem_rdy low for 3 cycles on byte offset 01 -> addr18/data8 held at 18'h048D1/8'hBE during the stall, done 3 cycles later than in case 1, err=0, all four bytes written once.
3. TIMEOUT=15, mem_rdy stuck 0 after byte 0 accepted -> mem_we drops after 15 stalled cycles; done=1 and err=1 for one cycle; addr18 holds 18'h048D1; next start in IDLE runs cleanly with err=0.
4. start pulsed again during WRITE with addrbus16=16'h5555 -> ignored; the transfer completes at the original addresses; addr_reg still 16'h1234 at done.
5. Assert rst asynchronously mid-WRITE at byte offset 10 -> mem_we, busy, addr18, data8 go 0 before the next edge; no done pulse; a following start behaves as in case 1.
6. addrbus16=16'hFFFF, databus32=32'h01020304, BIG_ENDIAN=1 -> addresses 18'h3FFFC..3FFFF with data 01,02,03,04; no write to 18'h00000.
